// File: rtl/traffic_mon_pkg.sv
// Shared types for the traffic signal-head monitor: light codes, fault codes,
// FSM state encodings and direction indices.
package traffic_mon_pkg;

    typedef enum logic [1:0] {
        LT_RED     = 2'b00,
        LT_GREEN   = 2'b01,
        LT_YELLOW  = 2'b10,
        LT_ILLEGAL = 2'b11
    } light_t;

    typedef enum logic [2:0] {
        FC_NONE           = 3'd0,
        FC_CONFLICT       = 3'd1,
        FC_ILLEGAL_CODE   = 3'd2,
        FC_BAD_TRANSITION = 3'd3,
        FC_COUNT_SKIP     = 3'd4,
        FC_STALL          = 3'd5
    } fault_code_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_ARM   = 2'b01,
        S_RUN   = 2'b10,
        S_FAULT = 2'b11
    } state_t;

    localparam logic [1:0] DIR_E = 2'd0;
    localparam logic [1:0] DIR_W = 2'd1;
    localparam logic [1:0] DIR_S = 2'd2;
    localparam logic [1:0] DIR_N = 2'd3;

    // Index of the lowest set bit; ties between directions go to the lowest index.
    function automatic logic [1:0] lowest_dir(input logic [3:0] v);
        logic [1:0] idx;
        idx = DIR_E;
        for (int i = 3; i >= 0; i--) begin
            if (v[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/traffic_dir_check.sv
// Per-direction sequencing checks: illegal light code, bad light transition,
// countdown skip, and whether anything changed since the previous sample.
module traffic_dir_check
    import traffic_mon_pkg::*;
(
    input  logic [3:0] cur_ct,
    input  logic [3:0] prev_ct,
    input  logic [1:0] cur_wt,
    input  logic [1:0] prev_wt,
    output logic       illegal_code,
    output logic       bad_transition,
    output logic       count_skip,
    output logic       changed
);

    logic wt_changed;
    logic ct_changed;
    logic legal_step;

    // A countdown may only step down by one (no wrap from 0) while the light is steady.
    always_comb begin
        wt_changed     = (cur_wt != prev_wt);
        ct_changed     = (cur_ct != prev_ct);
        legal_step     = ((prev_wt == LT_RED)    && (cur_wt == LT_GREEN))  ||
                         ((prev_wt == LT_GREEN)  && (cur_wt == LT_YELLOW)) ||
                         ((prev_wt == LT_YELLOW) && (cur_wt == LT_RED));
        illegal_code   = (cur_wt == LT_ILLEGAL);
        bad_transition = wt_changed && !legal_step;
        count_skip     = !wt_changed && ct_changed &&
                         ((prev_ct == 4'd0) || (cur_ct != (prev_ct - 4'd1)));
        changed        = wt_changed || ct_changed;
    end

endmodule

// File: rtl/traffic_sig_monitor.sv
// Receive-side safety/sequencing monitor for the four signal heads. Latches the
// first fault, blinks a fail-safe flash while faulted and counts rotations.
// Optional macro TRAFFIC_MON_TIMESTAMP_EN adds o_fault_time (clock count at fault entry).
module traffic_sig_monitor
    import traffic_mon_pkg::*;
#(
    parameter int STALL_LIMIT = 64,
    parameter int FLASH_DIV   = 8,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_enable,
    input  logic             i_clear,
    input  logic [3:0]       i_e_ct,
    input  logic [3:0]       i_w_ct,
    input  logic [3:0]       i_s_ct,
    input  logic [3:0]       i_n_ct,
    input  logic [1:0]       i_e_wt,
    input  logic [1:0]       i_w_wt,
    input  logic [1:0]       i_s_wt,
    input  logic [1:0]       i_n_wt,
    output logic [1:0]       o_state,
    output logic             o_fault,
    output logic [2:0]       o_fault_code,
    output logic [1:0]       o_fault_dir,
    output logic             o_flash,
    output logic [CNT_W-1:0] o_cycle_cnt
`ifdef TRAFFIC_MON_TIMESTAMP_EN
    ,
    output logic [15:0]      o_fault_time
`endif
);

    localparam int STALL_W = $clog2(STALL_LIMIT + 1);
    localparam int FDIV_W  = $clog2(FLASH_DIV + 1);

    state_t             state, state_nxt;
    logic [3:0][3:0]    cur_ct, prev_ct;
    logic [3:0][1:0]    cur_wt, prev_wt;
    logic [3:0]         illegal_v, bad_v, skip_v, chg_v, lit_v;
    logic [STALL_W-1:0] stall_cnt;
    logic [FDIV_W-1:0]  flash_div;
    fault_code_t        det_code, fault_code_q;
    logic [1:0]         det_dir, fault_dir_q;
    logic               stall_hit, raise_fault, fault_q, flash_q;
    logic [CNT_W-1:0]   cycle_cnt;

    assign cur_ct[DIR_E] = i_e_ct;
    assign cur_ct[DIR_W] = i_w_ct;
    assign cur_ct[DIR_S] = i_s_ct;
    assign cur_ct[DIR_N] = i_n_ct;
    assign cur_wt[DIR_E] = i_e_wt;
    assign cur_wt[DIR_W] = i_w_wt;
    assign cur_wt[DIR_S] = i_s_wt;
    assign cur_wt[DIR_N] = i_n_wt;

    for (genvar d = 0; d < 4; d++) begin : g_dir
        traffic_dir_check u_check (
            .cur_ct         (cur_ct[d]),
            .prev_ct        (prev_ct[d]),
            .cur_wt         (cur_wt[d]),
            .prev_wt        (prev_wt[d]),
            .illegal_code   (illegal_v[d]),
            .bad_transition (bad_v[d]),
            .count_skip     (skip_v[d]),
            .changed        (chg_v[d])
        );
        assign lit_v[d] = (cur_wt[d] == LT_GREEN) || (cur_wt[d] == LT_YELLOW);
    end

    assign stall_hit   = !(|chg_v) && (stall_cnt == STALL_W'(STALL_LIMIT - 1));
    assign raise_fault = (state == S_RUN) && i_enable && (det_code != FC_NONE);

    // Priority-encode this clock's violations: lowest code wins, then lowest direction.
    always_comb begin
        det_code = FC_NONE;
        det_dir  = DIR_E;
        if ((lit_v[DIR_E] || lit_v[DIR_W]) && (lit_v[DIR_S] || lit_v[DIR_N])) begin
            det_code = FC_CONFLICT;
            det_dir  = lowest_dir(lit_v);
        end else if (|illegal_v) begin
            det_code = FC_ILLEGAL_CODE;
            det_dir  = lowest_dir(illegal_v);
        end else if (|bad_v) begin
            det_code = FC_BAD_TRANSITION;
            det_dir  = lowest_dir(bad_v);
        end else if (|skip_v) begin
            det_code = FC_COUNT_SKIP;
            det_dir  = lowest_dir(skip_v);
        end else if (stall_hit) begin
            det_code = FC_STALL;
        end
    end

    // Next-state logic for IDLE/ARM/RUN/FAULT.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (i_enable) state_nxt = S_ARM;
            S_ARM:   state_nxt = S_RUN;
            S_RUN: begin
                if (!i_enable)        state_nxt = S_IDLE;
                else if (raise_fault) state_nxt = S_FAULT;
            end
            S_FAULT: if (i_clear) state_nxt = i_enable ? S_ARM : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Previous-sample capture and stall counter (restarted on entry to RUN).
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_ct   <= '0;
            prev_wt   <= '0;
            stall_cnt <= '0;
        end else begin
            if ((state == S_ARM) || (state == S_RUN)) begin
                prev_ct <= cur_ct;
                prev_wt <= cur_wt;
            end
            if (state == S_ARM) begin
                stall_cnt <= '0;
            end else if (state == S_RUN) begin
                if (|chg_v)
                    stall_cnt <= '0;
                else if (stall_cnt != STALL_W'(STALL_LIMIT))
                    stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end

    // First-fault latch and flash divider; everything clears on acknowledge.
    always_ff @(posedge clk) begin
        if (reset) begin
            fault_q      <= 1'b0;
            fault_code_q <= FC_NONE;
            fault_dir_q  <= DIR_E;
            flash_q      <= 1'b0;
            flash_div    <= '0;
        end else if (raise_fault) begin
            fault_q      <= 1'b1;
            fault_code_q <= det_code;
            fault_dir_q  <= det_dir;
            flash_q      <= 1'b1;
            flash_div    <= '0;
        end else if (state == S_FAULT) begin
            if (i_clear) begin
                fault_q      <= 1'b0;
                fault_code_q <= FC_NONE;
                fault_dir_q  <= DIR_E;
                flash_q      <= 1'b0;
                flash_div    <= '0;
            end else if (flash_div == FDIV_W'(FLASH_DIV - 1)) begin
                flash_q   <= ~flash_q;
                flash_div <= '0;
            end else begin
                flash_div <= flash_div + 1'b1;
            end
        end
    end

    // Rotation counter: one per clean east red->green step, saturating.
    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_cnt <= '0;
        end else if ((state == S_RUN) && i_enable && !raise_fault &&
                     (prev_wt[DIR_E] == LT_RED) && (cur_wt[DIR_E] == LT_GREEN) &&
                     (cycle_cnt != {CNT_W{1'b1}})) begin
            cycle_cnt <= cycle_cnt + 1'b1;
        end
    end

`ifdef TRAFFIC_MON_TIMESTAMP_EN
    logic [15:0] ts_cnt;

    // Free-running clock count, snapshotted when a fault is latched.
    always_ff @(posedge clk) begin
        if (reset) begin
            ts_cnt       <= '0;
            o_fault_time <= '0;
        end else begin
            ts_cnt <= ts_cnt + 16'd1;
            if (raise_fault)
                o_fault_time <= ts_cnt;
            else if ((state == S_FAULT) && i_clear)
                o_fault_time <= '0;
        end
    end
`endif

    assign o_state      = state;
    assign o_fault      = fault_q;
    assign o_fault_code = fault_code_q;
    assign o_fault_dir  = fault_dir_q;
    assign o_flash      = flash_q;
    assign o_cycle_cnt  = cycle_cnt;

endmodule

// File: tb/tb_traffic_sig_monitor.sv
// Self-checking bench for traffic_sig_monitor: directed scenarios followed by
// randomized traffic, all compared against a rule-level reference model.
module tb_traffic_sig_monitor;

    localparam int STALL = 64;
    localparam int FDIV  = 8;

    logic            clk = 1'b0;
    logic            t_reset = 1'b1;
    logic            t_enable = 1'b0;
    logic            t_clear = 1'b0;
    logic [3:0][3:0] t_ct = '0;
    logic [3:0][1:0] t_wt = '0;
    logic [1:0]      o_state;
    logic            o_fault;
    logic [2:0]      o_fault_code;
    logic [1:0]      o_fault_dir;
    logic            o_flash;
    logic [15:0]     o_cycle_cnt;
`ifdef TRAFFIC_MON_TIMESTAMP_EN
    logic [15:0]     o_fault_time;
`endif

    int total = 0;
    int bad = 0;

    // Reference model state (state: 0 idle, 1 arm, 2 run, 3 fault)
    int m_state = 0, m_code = 0, m_dir = 0, m_cnt = 0, m_unch = 0, m_age = 0;
    int m_pct[4], m_pwt[4];

    traffic_sig_monitor #(.STALL_LIMIT(STALL), .FLASH_DIV(FDIV), .CNT_W(16)) dut (
        .clk          (clk),
        .reset        (t_reset),
        .i_enable     (t_enable),
        .i_clear      (t_clear),
        .i_e_ct       (t_ct[0]),
        .i_w_ct       (t_ct[1]),
        .i_s_ct       (t_ct[2]),
        .i_n_ct       (t_ct[3]),
        .i_e_wt       (t_wt[0]),
        .i_w_wt       (t_wt[1]),
        .i_s_wt       (t_wt[2]),
        .i_n_wt       (t_wt[3]),
        .o_state      (o_state),
        .o_fault      (o_fault),
        .o_fault_code (o_fault_code),
        .o_fault_dir  (o_fault_dir),
        .o_flash      (o_flash),
        .o_cycle_cnt  (o_cycle_cnt)
`ifdef TRAFFIC_MON_TIMESTAMP_EN
        ,
        .o_fault_time (o_fault_time)
`endif
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%0d want=%0d at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic bit isLit(input int wt);
        return (wt == 1) || (wt == 2);
    endfunction

    // Red -> green -> yellow -> red is the only legal cycle of lights.
    function automatic bit legalStep(input int p, input int c);
        return (p < 3) && (((p + 1) % 3) == c);
    endfunction

    task automatic capturePrev();
        for (int d = 0; d < 4; d++) begin
            m_pct[d] = int'(t_ct[d]);
            m_pwt[d] = int'(t_wt[d]);
        end
    endtask

    // One clock of the rule-level model, using the inputs present at the edge.
    task automatic modelStep();
        int code, dir, uc, ct, wt;
        bit chg;
        if (t_reset) begin
            m_state = 0; m_code = 0; m_dir = 0; m_cnt = 0; m_unch = 0; m_age = 0;
            return;
        end
        case (m_state)
            0: if (t_enable) m_state = 1;
            1: begin capturePrev(); m_unch = 0; m_state = 2; end
            2: begin
                if (!t_enable) begin
                    m_state = 0;
                end else begin
                    code = 0; dir = 0; chg = 0;
                    for (int d = 0; d < 4; d++)
                        if (int'(t_ct[d]) != m_pct[d] || int'(t_wt[d]) != m_pwt[d]) chg = 1;
                    uc = chg ? 0 : m_unch + 1;
                    if ((isLit(int'(t_wt[0])) || isLit(int'(t_wt[1]))) &&
                        (isLit(int'(t_wt[2])) || isLit(int'(t_wt[3])))) begin
                        code = 1;
                        for (int d = 3; d >= 0; d--) if (isLit(int'(t_wt[d]))) dir = d;
                    end
                    if (code == 0)
                        for (int d = 3; d >= 0; d--) if (t_wt[d] == 2'd3) begin code = 2; dir = d; end
                    if (code == 0)
                        for (int d = 3; d >= 0; d--) begin
                            wt = int'(t_wt[d]);
                            if (wt != m_pwt[d] && !legalStep(m_pwt[d], wt)) begin code = 3; dir = d; end
                        end
                    if (code == 0)
                        for (int d = 3; d >= 0; d--) begin
                            ct = int'(t_ct[d]);
                            if (int'(t_wt[d]) == m_pwt[d] && ct != m_pct[d] && ct != m_pct[d] - 1) begin
                                code = 4; dir = d;
                            end
                        end
                    if (code == 0 && uc >= STALL) code = 5;
                    if (code != 0) begin
                        m_state = 3; m_code = code; m_dir = dir; m_age = 0;
                    end else if (m_pwt[0] == 0 && t_wt[0] == 2'd1 && m_cnt < 65535) begin
                        m_cnt++;
                    end
                    capturePrev();
                    m_unch = (uc < STALL) ? uc : STALL;
                end
            end
            default: begin
                if (t_clear) begin
                    m_state = t_enable ? 1 : 0; m_code = 0; m_dir = 0;
                end else begin
                    m_age++;
                end
            end
        endcase
    endtask

    // Present the current inputs for one clock, advance the model, then compare.
    task automatic applyStimulus();
        @(posedge clk);
        modelStep();
        #1;
        checkOutput("state", 32'(o_state), 32'(m_state));
        checkOutput("fault", 32'(o_fault), 32'(m_state == 3));
        checkOutput("code", 32'(o_fault_code), 32'(m_code));
        checkOutput("dir", 32'(o_fault_dir), 32'(m_dir));
        checkOutput("flash", 32'(o_flash), 32'(m_state == 3 && ((m_age / FDIV) % 2) == 0));
        checkOutput("cycle_cnt", 32'(o_cycle_cnt), 32'(m_cnt));
    endtask

    task automatic setDir(input int d, input int wt, input int ct);
        t_wt[d] = 2'(wt);
        t_ct[d] = 4'(ct);
    endtask

    task automatic setAllRed();
        for (int d = 0; d < 4; d++) setDir(d, 0, 0);
    endtask

    initial begin
        int n, r, d;
        setAllRed();
        // Reset state
        t_reset = 1'b1;
        applyStimulus();
        checkOutput("rst_state", 32'(o_state), 0);
        checkOutput("rst_fault", 32'(o_fault), 0);
        t_reset = 1'b0;
        t_enable = 1'b1;
        applyStimulus();
        checkOutput("arm_state", 32'(o_state), 1);
        applyStimulus();
        checkOutput("run_state", 32'(o_state), 2);

        // Two legal rotations
        for (int rep = 0; rep < 2; rep++) begin
            for (int c = 5; c >= 0; c--) begin setDir(0, 1, c); setDir(1, 1, c); applyStimulus(); end
            for (int c = 2; c >= 0; c--) begin setDir(0, 2, c); setDir(1, 2, c); applyStimulus(); end
            setDir(0, 0, 0); setDir(1, 0, 0); applyStimulus();
            for (int c = 5; c >= 0; c--) begin setDir(2, 1, c); setDir(3, 1, c); applyStimulus(); end
            for (int c = 2; c >= 0; c--) begin setDir(2, 2, c); setDir(3, 2, c); applyStimulus(); end
            setDir(2, 0, 0); setDir(3, 0, 0); applyStimulus();
        end
        checkOutput("rot_fault", 32'(o_fault), 0);
        checkOutput("rot_cnt", 32'(o_cycle_cnt), 2);

        // Conflict E and N green together, then flash pattern
        setDir(0, 1, 3); setDir(3, 1, 3);
        applyStimulus();
        checkOutput("cf_fault", 32'(o_fault), 1);
        checkOutput("cf_code", 32'(o_fault_code), 1);
        checkOutput("cf_dir", 32'(o_fault_dir), 0);
        checkOutput("cf_state", 32'(o_state), 3);
        checkOutput("cf_flash0", 32'(o_flash), 1);
        for (int i = 1; i <= 8; i++) begin
            applyStimulus();
            checkOutput("cf_flash", 32'(o_flash), 32'(i < 8));
        end
        setAllRed(); t_clear = 1'b1;
        applyStimulus();
        t_clear = 1'b0;
        applyStimulus();

        // Count skip on W together with illegal S code: illegal wins
        setDir(1, 1, 7); applyStimulus();
        setDir(1, 1, 5); setDir(2, 3, 0); applyStimulus();
        checkOutput("pri_code", 32'(o_fault_code), 2);
        checkOutput("pri_dir", 32'(o_fault_dir), 2);

        // Stall: constant inputs from ARM onwards
        setAllRed(); t_clear = 1'b1;
        applyStimulus();
        t_clear = 1'b0;
        n = 0;
        for (int i = 1; i <= 100; i++) begin
            applyStimulus();
            if (o_fault) begin n = i; break; end
        end
        checkOutput("stall_edges", 32'(n), 32'(STALL + 1));
        checkOutput("stall_code", 32'(o_fault_code), 5);
        t_clear = 1'b1;
        applyStimulus();
        checkOutput("clr_arm", 32'(o_state), 1);
        t_clear = 1'b0;
        applyStimulus();
        checkOutput("clr_run", 32'(o_state), 2);
        checkOutput("clr_cnt", 32'(o_cycle_cnt), 2);

        // Bad transition green->red on E, then reset
        setDir(0, 1, 3); applyStimulus();
        setDir(0, 0, 0); applyStimulus();
        checkOutput("bt_code", 32'(o_fault_code), 3);
        checkOutput("bt_dir", 32'(o_fault_dir), 0);
        t_reset = 1'b1;
        applyStimulus();
        checkOutput("rr_state", 32'(o_state), 0);
        checkOutput("rr_fault", 32'(o_fault), 0);
        checkOutput("rr_code", 32'(o_fault_code), 0);
        checkOutput("rr_flash", 32'(o_flash), 0);
        checkOutput("rr_cnt", 32'(o_cycle_cnt), 0);
        t_reset = 1'b0;
        setAllRed();

        // Randomized traffic
        for (int cyc = 0; cyc < 4000; cyc++) begin
            t_reset  = ($urandom_range(0, 199) == 0);
            t_enable = ($urandom_range(0, 59) != 0);
            t_clear  = (m_state == 3) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 9) == 0);
            r = int'($urandom_range(0, 99));
            d = int'($urandom_range(0, 3));
            if (r < 40) begin
            end else if (r < 65) begin
                if (t_ct[d] != 4'd0) t_ct[d] = t_ct[d] - 4'd1;
            end else if (r < 85) begin
                setDir(d, (t_wt[d] == 2'd3) ? 0 : (int'(t_wt[d]) + 1) % 3, int'($urandom_range(0, 15)));
            end else if (r < 92) begin
                t_ct[d] = 4'($urandom_range(0, 15));
            end else if (r < 96) begin
                t_wt[d] = 2'($urandom_range(0, 3));
            end else begin
                setAllRed();
            end
            applyStimulus();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
